lcd_i2c_sequencer: RTL and testbench

Sequences HD44780-class character LCD traffic over a PCF8574 I2C backpack through the I2C LCD transmitter core's byte interface. After reset it runs the fixed 4-bit power-up init. It then accepts command or character requests through a valid/ready port and expands each one into four I2C byte writes: high and low nibble, each strobed EN high then low. Each request is followed by a controller-timed execution delay. It sits between the AXI-lite register bank and the I2C byte transmitter.

---
 rtl/lcd_i2c_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_lcd_i2c_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_i2c_sequencer.sv
// HD44780 4-bit sequencer: runs the fixed power-up init, then expands each
// command/character request into four PCF8574 byte writes for the I2C transmitter.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// PWR_WAIT  | power-up (or post-NACK) settle delay before init entry 0
// LOAD      | build next tx_byte from ROM entry or captured request
// SEND      | tx_valid high, tx_byte held until tx_ready
// WAIT_DONE | waiting for the transmitter's tx_done for the launched byte
// DELAY     | execution delay after a complete entry / request
// IDLE      | init complete, ready for a request
module lcd_i2c_sequencer #(
   parameter logic [6:0]  I2C_ADDR     = 7'h27,
   parameter int unsigned POWERUP_CYC  = 4000000,
   parameter int unsigned INIT_DLY_CYC = 500000,
   parameter int unsigned CMD_DLY_CYC  = 5000,
   parameter int unsigned CLR_DLY_CYC  = 200000
) (
   input  logic       ACLK,
   input  logic       ARESETN,
   input  logic       backlight,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rs,
   input  logic [7:0] req_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [6:0] tx_addr,
   output logic [7:0] tx_byte,
   input  logic       tx_done,
   input  logic       tx_nack,
   output logic       init_done,
   output logic       busy,
   output logic       nack_err,
   input  logic       err_clr
);

   localparam int unsigned MAX_A   = (POWERUP_CYC > INIT_DLY_CYC) ? POWERUP_CYC : INIT_DLY_CYC;
   localparam int unsigned MAX_B   = (CMD_DLY_CYC > CLR_DLY_CYC) ? CMD_DLY_CYC : CLR_DLY_CYC;
   localparam int unsigned MAX_DLY = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int          CNT_W   = $clog2(MAX_DLY) + 1;

   localparam logic [CNT_W-1:0] PWR_C  = CNT_W'(POWERUP_CYC);
   localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_DLY_CYC);
   localparam logic [CNT_W-1:0] CMD_C  = CNT_W'(CMD_DLY_CYC);
   localparam logic [CNT_W-1:0] CLR_C  = CNT_W'(CLR_DLY_CYC);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   typedef enum logic [2:0] {
      PWR_WAIT  = 3'd0,
      LOAD      = 3'd1,
      SEND      = 3'd2,
      WAIT_DONE = 3'd3,
      DELAY     = 3'd4,
      IDLE      = 3'd5
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] dly_cnt, cnt_nxt;
   logic [2:0]       rom_idx, rom_nxt;
   logic [1:0]       byte_idx, bidx_nxt;
   logic             init_nxt, nack_nxt;
   logic             cur_rs, rs_nxt;
   logic [7:0]       cur_data, data_nxt;
   logic [7:0]       byte_nxt;

   logic             ent_rs, ent_full, ent_last;
   logic [7:0]       ent_data, rom_byte;
   logic [3:0]       ent_nib;
   logic [CNT_W-1:0] ent_dly, rom_dly, usr_dly;

   // Nibble-only entries keep their nibble in the upper half so byte_idx 0/1 pick it up.
   always_comb begin
      unique case (rom_idx)
         3'd0, 3'd1, 3'd2: rom_byte = 8'h30;
         3'd3:             rom_byte = 8'h20;
         3'd4:             rom_byte = 8'h28;
         3'd5:             rom_byte = 8'h0C;
         3'd6:             rom_byte = 8'h06;
         default:          rom_byte = 8'h01;
      endcase
   end

   assign rom_dly  = (rom_idx == 3'd0) ? INIT_C : ((rom_idx == 3'd7) ? CLR_C : CMD_C);
   assign usr_dly  = (!cur_rs && (cur_data == 8'h01 || cur_data == 8'h02 || cur_data == 8'h03))
                     ? CLR_C : CMD_C;

   assign ent_rs   = init_done ? cur_rs : 1'b0;
   assign ent_data = init_done ? cur_data : rom_byte;
   assign ent_full = init_done | rom_idx[2];
   assign ent_dly  = init_done ? usr_dly : rom_dly;
   assign ent_last = ent_full ? (byte_idx == 2'd3) : (byte_idx == 2'd1);
   assign ent_nib  = byte_idx[1] ? ent_data[3:0] : ent_data[7:4];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = dly_cnt;
      rom_nxt   = rom_idx;
      bidx_nxt  = byte_idx;
      init_nxt  = init_done;
      rs_nxt    = cur_rs;
      data_nxt  = cur_data;
      byte_nxt  = tx_byte;
      nack_nxt  = nack_err;
      if (err_clr) nack_nxt = 1'b0;

      unique case (state)
         PWR_WAIT: begin
            if (dly_cnt == '0) begin
               bidx_nxt  = 2'd0;
               state_nxt = LOAD;
            end else begin
               cnt_nxt = dly_cnt - ONE_C;
            end
         end
         LOAD: begin
            byte_nxt  = {ent_nib, backlight, ~byte_idx[0], 1'b0, ent_rs};
            state_nxt = SEND;
         end
         SEND: begin
            if (tx_ready) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_done) begin
               if (tx_nack) begin
                  // NACK set overrides a simultaneous err_clr
                  nack_nxt = 1'b1;
                  if (!init_done) begin
                     cnt_nxt   = PWR_C;
                     rom_nxt   = 3'd0;
                     state_nxt = PWR_WAIT;
                  end else begin
                     cnt_nxt   = CMD_C;
                     state_nxt = DELAY;
                  end
               end else if (ent_last) begin
                  cnt_nxt   = ent_dly;
                  state_nxt = DELAY;
               end else begin
                  bidx_nxt  = byte_idx + 2'd1;
                  state_nxt = LOAD;
               end
            end
         end
         DELAY: begin
            if (dly_cnt == '0) begin
               if (init_done) begin
                  state_nxt = IDLE;
               end else if (rom_idx == 3'd7) begin
                  init_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  rom_nxt   = rom_idx + 3'd1;
                  bidx_nxt  = 2'd0;
                  state_nxt = LOAD;
               end
            end else begin
               cnt_nxt = dly_cnt - ONE_C;
            end
         end
         IDLE: begin
            if (req_valid && init_done) begin
               rs_nxt    = req_rs;
               data_nxt  = req_data;
               bidx_nxt  = 2'd0;
               state_nxt = LOAD;
            end
         end
         default: begin
            cnt_nxt   = PWR_C;
            rom_nxt   = 3'd0;
            state_nxt = PWR_WAIT;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state     <= PWR_WAIT;
         dly_cnt   <= PWR_C;
         rom_idx   <= 3'd0;
         byte_idx  <= 2'd0;
         init_done <= 1'b0;
         nack_err  <= 1'b0;
         cur_rs    <= 1'b0;
         cur_data  <= 8'h00;
         tx_byte   <= 8'h00;
      end else begin
         state     <= state_nxt;
         dly_cnt   <= cnt_nxt;
         rom_idx   <= rom_nxt;
         byte_idx  <= bidx_nxt;
         init_done <= init_nxt;
         nack_err  <= nack_nxt;
         cur_rs    <= rs_nxt;
         cur_data  <= data_nxt;
         tx_byte   <= byte_nxt;
      end
   end

   assign tx_valid  = (state == SEND);
   assign req_ready = (state == IDLE) && init_done;
   assign busy      = (state != IDLE);
   assign tx_addr   = I2C_ADDR;

endmodule

// File: tb/tb_lcd_i2c_sequencer.sv
// Directed bench for lcd_i2c_sequencer: init byte stream, request vector table,
// backpressure, NACK handling and asynchronous reset.
module tb_lcd_i2c_sequencer;

   logic       ACLK = 1'b0;
   logic       ARESETN;
   logic       backlight;
   logic       req_valid;
   logic       req_ready;
   logic       req_rs;
   logic [7:0] req_data;
   logic       tx_valid;
   logic       tx_ready = 1'b1;
   logic [6:0] tx_addr;
   logic [7:0] tx_byte;
   logic       tx_done = 1'b0;
   logic       tx_nack = 1'b0;
   logic       init_done;
   logic       busy;
   logic       nack_err;
   logic       err_clr;

   always #5 ACLK = ~ACLK;

   lcd_i2c_sequencer #(
      .I2C_ADDR     (7'h27),
      .POWERUP_CYC  (100),
      .INIT_DLY_CYC (20),
      .CMD_DLY_CYC  (10),
      .CLR_DLY_CYC  (30)
   ) dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .backlight (backlight),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rs    (req_rs),
      .req_data  (req_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_addr   (tx_addr),
      .tx_byte   (tx_byte),
      .tx_done   (tx_done),
      .tx_nack   (tx_nack),
      .init_done (init_done),
      .busy      (busy),
      .nack_err  (nack_err),
      .err_clr   (err_clr)
   );

   typedef struct {
      logic        rs;
      logic [7:0]  data;
      logic        bl;
      logic [31:0] bytes;
      int          dly;
   } vec_t;

   vec_t       vecs [7];
   logic [7:0] init_exp [24];

   int checks = 0;
   int errors = 0;

   // owned by the transmitter model below
   int         neg_cnt = 0;
   int         done_neg = 0;
   int         cd = 0;
   int         stall_cnt = 0;
   logic [7:0] stall_ref = 8'h00;
   logic       pend_nack = 1'b0;
   logic [7:0] byte_log [$];
   int         hs_neg [$];

   // owned by the main sequence
   int stall_at = -1;
   int nack_at  = -1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge ACLK);
      #1;
   endtask

   // Transmitter model: tx_done 3 cycles after each accepted byte, optional stall/NACK.
   always @(negedge ACLK) begin
      neg_cnt++;
      tx_done = 1'b0;
      tx_nack = 1'b0;
      if (!ARESETN) begin
         cd        = 0;
         stall_cnt = 0;
         tx_ready  = 1'b1;
      end else begin
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               tx_done  = 1'b1;
               tx_nack  = pend_nack;
               done_neg = neg_cnt;
            end
         end
         if (stall_cnt > 0) begin
            check("stall_valid", {31'd0, tx_valid}, 32'd1);
            check("stall_byte", {24'd0, tx_byte}, {24'd0, stall_ref});
            stall_cnt--;
            if (stall_cnt == 0) tx_ready = 1'b1;
         end else if (tx_valid && byte_log.size() == stall_at) begin
            tx_ready  = 1'b0;
            stall_cnt = 5;
            stall_ref = tx_byte;
         end
         if (tx_valid && tx_ready) begin
            check("tx_addr", {25'd0, tx_addr}, 32'h27);
            pend_nack = (byte_log.size() == nack_at);
            byte_log.push_back(tx_byte);
            hs_neg.push_back(neg_cnt);
            cd = 3;
         end
      end
   end

   task automatic check_init(input int b, input int rel, input string tag);
      int n;
      for (n = 0; n < 5000 && !init_done; n++) tick();
      check($sformatf("%s_init_done", tag), {31'd0, init_done}, 32'd1);
      check($sformatf("%s_ready_with_done", tag), {31'd0, req_ready}, 32'd1);
      check($sformatf("%s_nbytes", tag), byte_log.size() - b, 32'd24);
      for (int i = 0; i < 24; i++)
         check($sformatf("%s_byte%0d", tag, i), {24'd0, byte_log[b+i]}, {24'd0, init_exp[i]});
      // last entry is the clear command: DELAY occupies CLR_DLY_CYC+1 cycles
      check($sformatf("%s_final_delay", tag), neg_cnt - done_neg, 32'd32);
      if (rel >= 0)
         check($sformatf("%s_powerup_window", tag),
               {31'd0, (hs_neg[b] - rel >= 100) && (hs_neg[b] - rel <= 104)}, 32'd1);
   endtask

   task automatic do_req(input vec_t v, input int nb, input bit clr_on_nack, input string tag);
      int n, base;
      for (n = 0; n < 5000 && !req_ready; n++) tick();
      check($sformatf("%s_ready", tag), {31'd0, req_ready}, 32'd1);
      backlight = v.bl;
      base      = byte_log.size();
      req_valid = 1'b1;
      req_rs    = v.rs;
      req_data  = v.data;
      tick();
      req_valid = 1'b0;
      check($sformatf("%s_ready_drop", tag), {31'd0, req_ready}, 32'd0);
      check($sformatf("%s_load_novalid", tag), {31'd0, tx_valid}, 32'd0);
      tick();
      check($sformatf("%s_send_valid", tag), {31'd0, tx_valid}, 32'd1);
      for (n = 0; n < 5000 && busy; n++) begin
         tick();
         if (clr_on_nack && tx_done && tx_nack) begin
            err_clr = 1'b1;
            tick();
            check($sformatf("%s_set_wins", tag), {31'd0, nack_err}, 32'd1);
            err_clr = 1'b0;
         end
      end
      check($sformatf("%s_idle", tag), {31'd0, busy}, 32'd0);
      check($sformatf("%s_ready_back", tag), {31'd0, req_ready}, 32'd1);
      // DELAY spans dly+1 cycles after the cycle carrying the final tx_done
      check($sformatf("%s_delay", tag), neg_cnt - done_neg, v.dly + 2);
      check($sformatf("%s_nbytes", tag), byte_log.size() - base, nb);
      for (int i = 0; i < nb; i++)
         check($sformatf("%s_byte%0d", tag, i), {24'd0, byte_log[base+i]},
               {24'd0, v.bytes[31-8*i -: 8]});
   endtask

   initial begin
      int   base, rel, gap;
      vec_t vn;

      vecs[0] = '{1'b1, 8'h41, 1'b1, 32'h4D491D19, 10};
      vecs[1] = '{1'b0, 8'h01, 1'b0, 32'h04001410, 30};
      vecs[2] = '{1'b0, 8'h02, 1'b1, 32'h0C082C28, 30};
      vecs[3] = '{1'b0, 8'h03, 1'b0, 32'h04003430, 30};
      vecs[4] = '{1'b0, 8'h04, 1'b1, 32'h0C084C48, 10};
      vecs[5] = '{1'b1, 8'h01, 1'b1, 32'h0D091D19, 10};
      vecs[6] = '{1'b0, 8'h00, 1'b0, 32'h04000400, 10};
      vn      = '{1'b1, 8'h41, 1'b1, 32'h4D490000, 10};
      init_exp = '{8'h3C, 8'h38, 8'h3C, 8'h38, 8'h3C, 8'h38, 8'h2C, 8'h28,
                   8'h2C, 8'h28, 8'h8C, 8'h88, 8'h0C, 8'h08, 8'hCC, 8'hC8,
                   8'h0C, 8'h08, 8'h6C, 8'h68, 8'h0C, 8'h08, 8'h1C, 8'h18};

      ARESETN   = 1'b0;
      backlight = 1'b1;
      req_valid = 1'b0;
      req_rs    = 1'b0;
      req_data  = 8'h00;
      err_clr   = 1'b0;
      repeat (3) tick();

      check("rst_tx_valid",  {31'd0, tx_valid},  32'd0);
      check("rst_tx_byte",   {24'd0, tx_byte},   32'd0);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_init_done", {31'd0, init_done}, 32'd0);
      check("rst_nack_err",  {31'd0, nack_err},  32'd0);
      check("rst_busy",      {31'd0, busy},      32'd1);
      check("rst_tx_addr",   {25'd0, tx_addr},   32'h27);

      base    = byte_log.size();
      rel     = neg_cnt;
      ARESETN = 1'b1;
      check_init(base, rel, "init");

      for (int i = 0; i < 7; i++) do_req(vecs[i], 4, 1'b0, $sformatf("vec%0d", i));

      stall_at = byte_log.size() + 1;
      do_req(vecs[0], 4, 1'b0, "bp");
      stall_at = -1;

      check("pre_nack_err", {31'd0, nack_err}, 32'd0);
      nack_at = byte_log.size() + 1;
      do_req(vn, 2, 1'b1, "nack");
      nack_at = -1;
      check("nack_sticky", {31'd0, nack_err}, 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("nack_cleared", {31'd0, nack_err}, 32'd0);
      do_req(vecs[1], 4, 1'b0, "post_nack");

      // asynchronous reset while a byte is presented
      for (int n = 0; n < 5000 && !req_ready; n++) tick();
      backlight = 1'b1;
      req_valid = 1'b1;
      req_rs    = 1'b1;
      req_data  = 8'h41;
      tick();
      req_valid = 1'b0;
      tick();
      check("mid_send_valid", {31'd0, tx_valid}, 32'd1);
      #2 ARESETN = 1'b0;
      #1;
      check("arst_tx_valid",  {31'd0, tx_valid},  32'd0);
      check("arst_init_done", {31'd0, init_done}, 32'd0);
      check("arst_busy",      {31'd0, busy},      32'd1);
      tick();
      tick();
      base    = byte_log.size();
      rel     = neg_cnt;
      ARESETN = 1'b1;
      check_init(base, rel, "rerun");

      // NACK on the fifth init byte restarts the whole init
      ARESETN = 1'b0;
      tick();
      tick();
      base    = byte_log.size();
      nack_at = base + 4;
      ARESETN = 1'b1;
      check_init(base + 5, -1, "ninit");
      nack_at = -1;
      for (int i = 0; i < 5; i++)
         check($sformatf("ninit_pre%0d", i), {24'd0, byte_log[base+i]}, {24'd0, init_exp[i]});
      gap = hs_neg[base+5] - (hs_neg[base+4] + 3);
      check("ninit_restart_gap", {31'd0, (gap >= 100) && (gap <= 104)}, 32'd1);
      check("ninit_nack_err", {31'd0, nack_err}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
